// File: rtl/a2d_round_robin_seq.sv
// Round-robin A2D sequencer: polls four ADC channels through the SPI master,
// two transactions per channel, and latches each 12-bit result into its slot.
module a2d_round_robin_seq #(
  parameter int         PERIOD  = 4096,
  parameter int         TIMEOUT = 1024,
  parameter logic [2:0] CH0_SEL = 3'd0,
  parameter logic [2:0] CH1_SEL = 3'd1,
  parameter logic [2:0] CH2_SEL = 3'd4,
  parameter logic [2:0] CH3_SEL = 3'd6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] res0,
  output logic [11:0] res1,
  output logic [11:0] res2,
  output logic [11:0] res3,
  output logic        cnv_cmplt,
  output logic        err
);

  localparam logic [15:0] LP_TICK_AT   = 16'(PERIOD - 1);
  localparam logic [15:0] LP_WDOG_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD1,
    WAIT1,
    GAP,
    CMD2,
    WAIT2,
    STORE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_slot;
  logic [1:0]  w_slot_next;
  logic [15:0] r_timer;
  logic [15:0] r_wdog;
  logic        r_done_q;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic        r_cnv;
  logic        r_err;

  logic        w_tick;
  logic        w_cmplt;
  logic        w_wdog_expired;
  logic        w_round_start;
  logic        w_store_last;
  logic        w_abort;
  logic [2:0]  w_sel_next;

  assign w_tick         = (r_timer == LP_TICK_AT);
  // Only a fresh rising edge counts; a done level left over from the previous
  // transaction must not complete the current one.
  assign w_cmplt        = done & ~r_done_q;
  assign w_wdog_expired = (r_wdog == LP_WDOG_LAST);

  always_comb begin
    w_state_next  = r_state;
    w_slot_next   = r_slot;
    w_round_start = 1'b0;
    w_store_last  = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick || start) begin
          w_state_next  = CMD1;
          w_slot_next   = 2'd0;
          w_round_start = 1'b1;
        end
      end
      CMD1:  w_state_next = WAIT1;
      WAIT1: begin
        if (w_cmplt) begin
          w_state_next = GAP;
        end else if (w_wdog_expired) begin
          w_state_next = IDLE;
          w_abort      = 1'b1;
        end
      end
      GAP:   w_state_next = CMD2;
      CMD2:  w_state_next = WAIT2;
      WAIT2: begin
        if (w_cmplt) begin
          w_state_next = STORE;
        end else if (w_wdog_expired) begin
          w_state_next = IDLE;
          w_abort      = 1'b1;
        end
      end
      STORE: begin
        if (r_slot == 2'd3) begin
          w_state_next = IDLE;
          w_store_last = 1'b1;
        end else begin
          w_slot_next  = r_slot + 2'd1;
          w_state_next = CMD1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_sel_next = CH0_SEL;
    case (w_slot_next)
      2'd1:    w_sel_next = CH1_SEL;
      2'd2:    w_sel_next = CH2_SEL;
      2'd3:    w_sel_next = CH3_SEL;
      default: w_sel_next = CH0_SEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_slot   <= 2'd0;
      r_timer  <= 16'd0;
      r_wdog   <= 16'd0;
      r_done_q <= 1'b0;
      r_wrt    <= 1'b0;
      r_cmd    <= 16'h0000;
      r_cnv    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_slot   <= w_slot_next;
      r_done_q <= done;
      r_timer  <= (w_round_start || w_tick) ? 16'd0 : r_timer + 16'd1;

      if (r_state == CMD1 || r_state == CMD2) begin
        r_wdog <= 16'd0;
      end else if (r_state == WAIT1 || r_state == WAIT2) begin
        r_wdog <= r_wdog + 16'd1;
      end

      // wrt is high exactly while in a CMD state; cmd only changes on CMD1
      // entry, so CMD2 reissues the identical word.
      r_wrt <= (w_state_next == CMD1) || (w_state_next == CMD2);
      if (w_state_next == CMD1) begin
        r_cmd <= {2'b00, w_sel_next, 11'h000};
      end

      r_cnv <= w_store_last;
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_res
      logic [11:0] r_val;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_val <= 12'h000;
        end else if (r_state == STORE && r_slot == 2'(gi)) begin
          r_val <= rd_data[11:0];
        end
      end
    end
  endgenerate

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign res0      = g_res[0].r_val;
  assign res1      = g_res[1].r_val;
  assign res2      = g_res[2].r_val;
  assign res3      = g_res[3].r_val;
  assign cnv_cmplt = r_cnv;
  assign err       = r_err;

endmodule
